// File: rtl/alu_mul_seq.sv
// Sequential 16-bit shift-and-add multiplier driving a shared Hack ALU.
// Ports: in_* request handshake, out_* result handshake, alu_* ALU drive/return; out_ovf when ALU_MUL_OVF_EN.
module alu_mul_seq #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic [W-1:0] alu_x,
  output logic [W-1:0] alu_y,
  output logic         alu_zx,
  output logic         alu_nx,
  output logic         alu_zy,
  output logic         alu_ny,
  output logic         alu_f,
  output logic         alu_no,
`ifdef ALU_MUL_OVF_EN
  output logic         out_ovf,
`endif
  input  logic [W-1:0] alu_out
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] DBL  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]   state;
  logic [W-1:0] acc;
  logic [W-1:0] mcand;
  logic [W-1:0] mplr;
  logic         st_add;
  logic         st_dbl;
  logic         hi_zero;

  assign st_add  = (state == ADD);
  assign st_dbl  = (state == DBL);
  // multiplier bits still to consume after the current LSB
  assign hi_zero = (mplr[W-1:1] == '0);

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign out_result = acc;

  // {zx,nx,zy,ny,f,no}: 101010 -> 0, 000010 -> x+y
  always_comb begin
    alu_x = '0;
    alu_y = '0;
    {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = 6'b101010;
    unique case (1'b1)
      st_add: begin
        alu_x = acc;
        alu_y = mcand;
        {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = 6'b000010;
      end
      st_dbl: begin
        alu_x = mcand;
        alu_y = mcand;
        {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = 6'b000010;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      mcand <= '0;
      mplr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc   <= '0;
            mcand <= in_a;
            mplr  <= in_b;
            if (in_b == '0)
              state <= DONE;
            else if (in_b[0])
              state <= ADD;
            else
              state <= DBL;
          end
        end
        ADD: begin
          acc   <= alu_out;
          state <= hi_zero ? DONE : DBL;
        end
        DBL: begin
          mcand <= alu_out;
          mplr  <= mplr >> 1;
          if (hi_zero)
            state <= DONE;
          else if (mplr[1])
            state <= ADD;
          else
            state <= DBL;
        end
        DONE: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_MUL_OVF_EN
  // sticky: a carry out of any add, or a set MSB shifted out while bits remain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      out_ovf <= 1'b0;
    else if (state == IDLE && in_valid)
      out_ovf <= 1'b0;
    else if (st_add && (alu_out < acc))
      out_ovf <= 1'b1;
    else if (st_dbl && mcand[W-1] && !hi_zero)
      out_ovf <= 1'b1;
  end
`endif

endmodule
